// File: rtl/svc_soc_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the io_* bus: TXDATA pushes into a byte FIFO,
// STATUS reports FIFO level and flags, and a baud-timed serializer drives uart_tx.
module svc_soc_io_uart_tx #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0100,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  output logic        uart_tx
);

  localparam int unsigned DIV    = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DIV_M1      = CNT_W'(DIV - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT    = CNT_FW'(FIFO_DEPTH);
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_FW-1:0] count_q;
  logic              ovf_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [31:0]       rdata_q;

  logic        wr_tx, wr_st, empty, full, bit_end, pop, push, busy;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_bits;

  assign wr_tx   = io_wen & (io_waddr == BASE_ADDR) & io_wstrb[0];
  assign wr_st   = io_wen & (io_waddr == STATUS_ADDR) & io_wstrb[0] & io_wdata[3];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign bit_end = (baud_q == '0);
  assign head    = mem_q[rptr_q];
  // The serializer takes the head either from idle or at the end of a stop bit.
  assign pop     = ~empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));
  // A same-edge pop frees a slot, so a push into a full FIFO still lands.
  assign push    = wr_tx & (~full | pop);
  assign busy    = (state_q != StIdle) | ~empty;
  assign status  = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy, empty, full};

  assign unused_bits = ^{io_wdata[31:8], io_wstrb[3:1]};

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_FW'(1);
      else if (pop && !push) count_q <= count_q - CNT_FW'(1);
      if (wr_tx && full && !pop) ovf_q <= 1'b1;
      else if (wr_st)            ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != StIdle && !bit_end) baud_d = baud_q - CNT_W'(1);
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          shift_d = head;
          tx_d    = 1'b0;
          baud_d  = DIV_M1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          baud_d  = DIV_M1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = DIV_M1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (pop) begin
            state_d = StStart;
            shift_d = head;
            tx_d    = 1'b0;
            baud_d  = DIV_M1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (io_ren) rdata_q <= (io_raddr == STATUS_ADDR) ? status : 32'h0;
    end
  end

  assign uart_tx  = tx_q;
  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_svc_soc_io_uart_tx.sv
// Scoreboard bench for svc_soc_io_uart_tx: expected bytes are queued on each accepted
// TXDATA write and checked cycle-by-cycle against frames seen on uart_tx.
module tb_svc_soc_io_uart_tx;

  localparam int          DIV  = 8;
  localparam logic [31:0] BASE = 32'h8000_0100;
  localparam logic [31:0] STAT = 32'h8000_0104;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cyc = 0;
  bit mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int starts[$];

  svc_soc_io_uart_tx #(
    .CLOCK_FREQ(8_000_000),
    .BAUD_RATE (1_000_000),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_wen  (io_wen),
    .io_waddr(io_waddr),
    .io_wdata(io_wdata),
    .io_wstrb(io_wstrb),
    .io_ren  (io_ren),
    .io_raddr(io_raddr),
    .io_rdata(io_rdata),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    io_wen   = 1'b1;
    io_waddr = addr;
    io_wdata = data;
    io_wstrb = strb;
    @(posedge clk);
    #1;
    io_wen = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    io_write(BASE, {24'h0, b}, 4'b0001);
  endtask

  task automatic io_read(input logic [31:0] addr, output logic [31:0] d);
    io_ren   = 1'b1;
    io_raddr = addr;
    @(posedge clk);
    #1;
    io_ren = 1'b0;
    d = io_rdata;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", {31'h0, (exp_q.size() == 0 && !mon_busy)}, 32'h1);
    idle(2);
  endtask

  task automatic wait_start(input int n0, input int budget);
    int n = 0;
    while (starts.size() <= n0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_start", {31'h0, (starts.size() > n0)}, 32'h1);
  endtask

  // Line monitor: every cycle of a frame must match {stop, data, start} for the queued byte.
  initial begin : monitor
    logic [7:0] exp_b, got_b;
    logic [9:0] frame;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'h1, 32'h0);
          exp_b = 8'h00;
        end else begin
          exp_b = exp_q.pop_front();
        end
        frame   = {1'b1, exp_b, 1'b0};
        bad     = 0;
        got_b   = 8'h00;
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < DIV && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            else begin
              if (uart_tx !== frame[b]) bad++;
              if (c == DIV / 2 && b >= 1 && b <= 8) got_b[b-1] = uart_tx;
            end
          end
        end
        if (!aborted) begin
          check("frame_byte", {24'h0, got_b}, {24'h0, exp_b});
          check("frame_shape_bad_cycles", bad, 32'h0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    int n0, s0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("reset_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_rdata", io_rdata, 32'h0);
    io_read(STAT, d);
    check("reset_status", d, 32'h0000_0002);

    // Single frame and push-to-start latency
    n0 = starts.size();
    send(8'hA5);
    wait_start(n0, 10);
    check("latency", starts[n0] - wr_cyc, 32'd1);
    wait_drain(200);
    io_read(STAT, d);
    check("status_after_a5", d, 32'h0000_0002);

    // Back-to-back frames
    n0 = starts.size();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    io_read(STAT, d);
    check("status_mid_frame", d, 32'h0000_0204);
    wait_drain(400);
    check("gap_1", starts[n0+1] - starts[n0], 32'd80);
    check("gap_2", starts[n0+2] - starts[n0+1], 32'd80);

    // Fill, overflow, clear, then push on the pop edge while full
    n0 = starts.size();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h05);
    io_write(BASE, 32'h0000_0006, 4'b0001);
    io_read(STAT, d);
    check("status_overflow", d, 32'h0000_040D);
    io_write(STAT, 32'h0000_0008, 4'b0001);
    io_read(STAT, d);
    check("status_ovf_cleared", d, 32'h0000_0405);
    s0 = starts[n0];
    while (cyc < s0 + 79) begin
      @(posedge clk);
      #1;
    end
    send(8'h07);
    io_read(STAT, d);
    check("status_push_on_pop", d, 32'h0000_0405);
    wait_drain(700);

    // Read decode, hold and partial-strobe write
    io_read(STAT, d);
    check("status_idle", d, 32'h0000_0002);
    idle(3);
    check("rdata_hold", io_rdata, 32'h0000_0002);
    io_read(32'h8000_0108, d);
    check("read_unmapped", d, 32'h0);
    io_read(STAT, d);
    io_read(BASE, d);
    check("read_txdata", d, 32'h0);
    n0 = starts.size();
    io_write(BASE, 32'h0000_00FF, 4'b1110);
    io_write(BASE + 32'd8, 32'h0000_00FF, 4'b1111);
    idle(20);
    check("no_push_frames", starts.size(), n0);
    io_read(STAT, d);
    check("status_no_push", d, 32'h0000_0002);

    // Reset during data bits
    n0 = starts.size();
    send(8'h00);
    send(8'h55);
    wait_start(n0, 10);
    idle(28);
    check("pre_reset_tx_low", {31'h0, uart_tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_tx", {31'h0, uart_tx}, 32'h1);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    n0 = starts.size();
    io_read(STAT, d);
    check("status_after_reset", d, 32'h0000_0002);
    idle(100);
    check("no_frame_after_reset", starts.size(), n0);
    check("tx_idle_after_reset", {31'h0, uart_tx}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
